// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the register-file write port between the in-order WB stage and the
//   out-of-band multiply/divide unit. MDU results wait in a DEPTH-entry FIFO
//   and are written whenever WB is idle. If WB keeps the port for STARVE_MAX
//   cycles while results are queued, the pipeline is stalled for one cycle so
//   that the queue head gets the port.
//
//   Optional build macro: WBARB_BYPASS_EN -- with the queue empty and WB
//   idle, a valid MDU result goes straight to the write port (no push).
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   wb_valid/wb_addr/wb_data     WB write request (held by pipe while stalled)
//   mdu_valid/mdu_addr/mdu_data  MDU result, accepted when mdu_ready
//   mdu_ready                    queue not full
//   pipe_stall                   freeze pipeline; WB request not consumed
//   rf_we/rf_waddr/rf_wdata      registered write port (latency 1)
//   q_count                      queue occupancy
module wb_port_arbiter #(
  parameter int DEPTH      = 4,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_valid,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     mdu_valid,
  input  logic [ADDR_W-1:0]        mdu_addr,
  input  logic [DATA_W-1:0]        mdu_data,
  output logic                     mdu_ready,
  output logic                     pipe_stall,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  localparam logic [PW:0]   FULL = (PW + 1)'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  wr_req_t          mem_q [DEPTH];
  wr_req_t          mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  logic    empty, full, push, pop, byp, gnt;
  wr_req_t g_req;

  always_comb begin
    empty      = (cnt_q == '0);
    full       = (cnt_q == FULL);
    // rst gating keeps pushes out while the block is held in reset.
    mdu_ready  = !full && !rst;
    pipe_stall = (starve_q == SMAX) && !empty;
`ifdef WBARB_BYPASS_EN
    byp        = empty && !wb_valid && mdu_valid;
`else
    byp        = 1'b0;
`endif
    push       = mdu_valid && mdu_ready && !byp;
    // Head wins when starving, or whenever WB has nothing to write.
    pop        = !empty && (pipe_stall || !wb_valid);
    gnt        = pop || wb_valid || byp;

    g_req = '{addr: wb_addr, data: wb_data};
    if (pop)      g_req = mem_q[rd_ptr_q];
    else if (byp) g_req = '{addr: mdu_addr, data: mdu_data};

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{addr: mdu_addr, data: mdu_data};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    cnt_d = cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};

    // Non-empty without a pop means WB took the port this cycle.
    starve_d = starve_q;
    if (pop || empty)          starve_d = '0;
    else if (starve_q != SMAX) starve_d = starve_q + 1'b1;

    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (gnt) begin
      rf_we_d    = (g_req.addr != '0);
      rf_waddr_d = g_req.addr;
      rf_wdata_d = g_req.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) mem_q <= mem_d;

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign q_count  = cnt_q;

endmodule
